// File: rtl/ttl_bus_latch_ctl.sv
// Bus-side control for a pair of 74F374 octal registers on a 68010-style port.
// Synchronises the CPU strobes and produces lane latch enables, OE_N and DTACK_N.
module ttl_bus_latch_ctl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned OE_HOLD     = 1
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic AS_N,
    input  logic UDS_N,
    input  logic LDS_N,
    input  logic RW,
    input  logic SEL,
    output logic LATCH_U,
    output logic LATCH_L,
    output logic OE_U_N,
    output logic OE_L_N,
    output logic DTACK_N,
    output logic BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [3:0] OH = 4'(OE_HOLD);
    localparam logic [4:0] SYNC_RST = 5'b11110;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] lanes;
    logic       rd;
    logic [4:0] sync1;
    logic [4:0] sync2;

    logic as_s;
    logic uds_s;
    logic lds_s;
    logic rw_s;
    logic sel_s;
    logic start;

    assign {as_s, uds_s, lds_s, rw_s, sel_s} = sync2;
    assign start = ~as_s & sel_s & (~uds_s | ~lds_s);

    // Order: {AS_N, UDS_N, LDS_N, RW, SEL}
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {AS_N, UDS_N, LDS_N, RW, SEL};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            lanes   <= 2'b00;
            rd      <= 1'b1;
            LATCH_U <= 1'b0;
            LATCH_L <= 1'b0;
            OE_U_N  <= 1'b1;
            OE_L_N  <= 1'b1;
            DTACK_N <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            LATCH_U <= 1'b0;
            LATCH_L <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        lanes  <= {~uds_s, ~lds_s};
                        rd     <= rw_s;
                        OE_U_N <= ~(rw_s & ~uds_s);
                        OE_L_N <= ~(rw_s & ~lds_s);
                        BUSY   <= 1'b1;
                        if (WS == 4'd0) begin
                            state   <= ST_ACK;
                            DTACK_N <= 1'b0;
                            LATCH_U <= ~rw_s & ~uds_s;
                            LATCH_L <= ~rw_s & ~lds_s;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WS;
                        end
                    end
                end
                ST_WAIT: begin
                    // An abort wins over the final wait cycle: never ack a dropped strobe
                    if (as_s) begin
                        state  <= ST_IDLE;
                        OE_U_N <= 1'b1;
                        OE_L_N <= 1'b1;
                        BUSY   <= 1'b0;
                    end else if (cnt == 4'd1) begin
                        state   <= ST_ACK;
                        DTACK_N <= 1'b0;
                        LATCH_U <= ~rd & lanes[1];
                        LATCH_L <= ~rd & lanes[0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (as_s) begin
                        state   <= ST_RECOVER;
                        DTACK_N <= 1'b1;
                        cnt     <= OH;
                    end
                end
                ST_RECOVER: begin
                    if (cnt <= 4'd1) begin
                        state  <= ST_IDLE;
                        OE_U_N <= 1'b1;
                        OE_L_N <= 1'b1;
                        BUSY   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_bus_latch_ctl.sv
// Scoreboard bench: two instances (WS=2/OH=1 and WS=0/OH=3) share one bus.
// A transaction-level model predicts each bus cycle; a monitor checks them.
module tb_ttl_bus_latch_ctl;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic AS_N = 1'b1;
    logic UDS_N = 1'b1;
    logic LDS_N = 1'b1;
    logic RW = 1'b1;
    logic SEL = 1'b0;

    logic [1:0] lu, ll, oeu, oel, dt, bsy;

    int ws_p[2] = '{2, 0};
    int oh_p[2] = '{1, 3};

    ttl_bus_latch_ctl #(.WAIT_STATES(2), .OE_HOLD(1)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .AS_N(AS_N), .UDS_N(UDS_N),
        .LDS_N(LDS_N), .RW(RW), .SEL(SEL),
        .LATCH_U(lu[0]), .LATCH_L(ll[0]), .OE_U_N(oeu[0]),
        .OE_L_N(oel[0]), .DTACK_N(dt[0]), .BUSY(bsy[0])
    );

    ttl_bus_latch_ctl #(.WAIT_STATES(0), .OE_HOLD(3)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .AS_N(AS_N), .UDS_N(UDS_N),
        .LDS_N(LDS_N), .RW(RW), .SEL(SEL),
        .LATCH_U(lu[1]), .LATCH_L(ll[1]), .OE_U_N(oeu[1]),
        .OE_L_N(oel[1]), .DTACK_N(dt[1]), .BUSY(bsy[1])
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int       start;
        int       blen;
        bit       acked;
        bit [1:0] lanes;
        bit       rw;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   idle_at[2];
    bit   mon_en = 1'b0;

    // Bus-cycle model: AS_N first seen low at edge t0, first seen high at t0+h.
    // A synced input acts two edges after it is sampled.
    task automatic model(input int i, input int t0, input int h,
                         input bit [1:0] lanes, input bit rw, input bit sel,
                         output int st);
        int   start;
        int   rel;
        exp_t e;
        st = -1;
        if (!sel || lanes == 2'b00) return;
        start = (t0 + 2 > idle_at[i] + 1) ? t0 + 2 : idle_at[i] + 1;
        rel = t0 + h + 2;
        if (start >= rel) return;
        e.start = start;
        e.lanes = lanes;
        e.rw = rw;
        if (rel <= start + ws_p[i]) begin
            e.acked = 1'b0;
            idle_at[i] = rel;
        end else begin
            e.acked = 1'b1;
            idle_at[i] = rel + oh_p[i];
        end
        e.blen = idle_at[i] - start;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
        st = start;
    endtask

    task automatic do_txn(input bit [1:0] lanes, input bit rw, input bit sel,
                          input int h, input int g, input bit scramble);
        int t0;
        int s0;
        int s1;
        bit scr;
        @(posedge CLK);
        #1;
        t0 = cyc + 1;
        AS_N = 1'b0;
        UDS_N = ~lanes[1];
        LDS_N = ~lanes[0];
        RW = rw;
        SEL = sel;
        model(0, t0, h, lanes, rw, sel, s0);
        model(1, t0, h, lanes, rw, sel, s1);
        scr = scramble && s0 == t0 + 2 && s1 == t0 + 2;
        repeat (h) begin
            @(posedge CLK);
            #1;
            if (scr && cyc == t0 + 3) begin
                {UDS_N, LDS_N, RW, SEL} = 4'($urandom);
            end
        end
        AS_N = 1'b1;
        UDS_N = 1'b1;
        LDS_N = 1'b1;
        RW = 1'b1;
        SEL = 1'b0;
        repeat (g) @(posedge CLK);
    endtask

    int       b_start[2];
    int       d_fall[2];
    int       lu_n[2];
    int       ll_n[2];
    bit       lat_bad[2];
    bit [1:0] oe_seen[2];
    bit       p_busy[2] = '{0, 0};
    bit       p_dt[2] = '{1, 1};

    always @(negedge CLK) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                bit   have;
                if (bsy[i] && !p_busy[i]) begin
                    chk($sformatf("u%0d_start_expected", i),
                        (i == 0 ? q0.size() : q1.size()) > 0 ? 1 : 0, 1);
                    b_start[i] = cyc;
                    d_fall[i] = -1;
                    lu_n[i] = 0;
                    ll_n[i] = 0;
                    lat_bad[i] = 1'b0;
                    oe_seen[i] = 2'b00;
                end
                if (bsy[i]) begin
                    if (!dt[i] && p_dt[i]) d_fall[i] = cyc;
                    if (lu[i]) begin
                        lu_n[i]++;
                        if (cyc != d_fall[i]) lat_bad[i] = 1'b1;
                    end
                    if (ll[i]) begin
                        ll_n[i]++;
                        if (cyc != d_fall[i]) lat_bad[i] = 1'b1;
                    end
                    oe_seen[i] |= {~oeu[i], ~oel[i]};
                end
                if (!bsy[i] && p_busy[i]) begin
                    have = (i == 0) ? q0.size() > 0 : q1.size() > 0;
                    if (have) begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("u%0d_start_cyc", i), b_start[i], e.start);
                        chk($sformatf("u%0d_busy_len", i), cyc - b_start[i], e.blen);
                        chk($sformatf("u%0d_acked", i), d_fall[i] >= 0 ? 1 : 0,
                            int'(e.acked));
                        if (e.acked) begin
                            chk($sformatf("u%0d_dtack_lat", i),
                                d_fall[i] - b_start[i], ws_p[i]);
                        end
                        chk($sformatf("u%0d_latch_u_cnt", i), lu_n[i],
                            (e.acked && !e.rw && e.lanes[1]) ? 1 : 0);
                        chk($sformatf("u%0d_latch_l_cnt", i), ll_n[i],
                            (e.acked && !e.rw && e.lanes[0]) ? 1 : 0);
                        chk($sformatf("u%0d_latch_timing", i), int'(lat_bad[i]), 0);
                        chk($sformatf("u%0d_oe_lanes", i), int'(oe_seen[i]),
                            e.rw ? int'(e.lanes) : 0);
                    end else begin
                        chk($sformatf("u%0d_end_expected", i), 0, 1);
                    end
                end
                if (!bsy[i]) begin
                    chk($sformatf("u%0d_idle_outputs", i),
                        int'({lu[i], ll[i], oeu[i], oel[i], dt[i]}), 5'b00111);
                end
                p_busy[i] = bsy[i];
                p_dt[i] = dt[i];
            end
        end
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_reset_outputs", i),
                int'({lu[i], ll[i], oeu[i], oel[i], dt[i], bsy[i]}), 6'b001110);
        end
        RESET_N = 1'b1;
        idle_at[0] = cyc;
        idle_at[1] = cyc;
        mon_en = 1'b1;

        // word write, lower-byte read, aborts, back-to-back writes, deselected
        do_txn(2'b11, 1'b0, 1'b1, 6, 5, 1'b0);
        do_txn(2'b01, 1'b1, 1'b1, 6, 5, 1'b0);
        do_txn(2'b11, 1'b0, 1'b1, 1, 5, 1'b0);
        do_txn(2'b10, 1'b1, 1'b1, 2, 5, 1'b0);
        do_txn(2'b11, 1'b0, 1'b1, 4, 0, 1'b0);
        do_txn(2'b10, 1'b0, 1'b1, 4, 0, 1'b0);
        do_txn(2'b01, 1'b0, 1'b1, 10, 5, 1'b0);
        do_txn(2'b11, 1'b0, 1'b0, 6, 5, 1'b0);
        do_txn(2'b00, 1'b1, 1'b1, 6, 5, 1'b0);

        for (int n = 0; n < 80; n++) begin
            do_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) != 0, $urandom_range(1, 8),
                   $urandom_range(0, 5), 1'b1);
        end

        repeat (30) @(posedge CLK);
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);

        // read held in ACK, then asynchronous reset between clock edges
        mon_en = 1'b0;
        @(posedge CLK);
        #1;
        AS_N = 1'b0;
        LDS_N = 1'b0;
        RW = 1'b1;
        SEL = 1'b1;
        for (int k = 0; k < 20 && dt[0]; k++) @(negedge CLK);
        chk("mid_ack_dtack_low", int'(dt[0]), 0);
        chk("mid_ack_oe_l_low", int'(oel[0]), 0);
        chk("mid_ack_busy", int'(bsy[0]), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_async_reset_outputs", i),
                int'({lu[i], ll[i], oeu[i], oel[i], dt[i], bsy[i]}), 6'b001110);
        end
        AS_N = 1'b1;
        LDS_N = 1'b1;
        SEL = 1'b0;
        repeat (2) @(posedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
